// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into instruction memory and holds the IF/ID
// register, with hazard freeze, control-flow redirect and halt handling.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_RUN    | fetching one word per cycle unless a hazard or resolve intervenes
//  S_WAIT   | control instruction pending in ID; bubbles until branch_resolve
//  S_HALTED | halt opcode fetched; everything frozen until rst
module fetch_unit #(
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]  HALT_OPC  = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_hazard,
   input  logic        PC_hazard,
   input  logic        branch_resolve,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        call,
   input  logic [11:0] call_target,
   input  logic        ret,
   input  logic [15:0] ret_addr,
   input  logic [15:0] imem_data,
   output logic [15:0] imem_addr,
   output logic        imem_rd_en,
   output logic [15:0] instruction,
   output logic [15:0] PC_out,
   output logic        valid_out,
   output logic        PC_update,
   output logic        halted,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc_reg, pc_nxt, pc_inc, target;
   logic [15:0] instr_nxt, pc_out_nxt, stall_nxt;
   logic        valid_nxt, upd_nxt, stall_inc;

   assign pc_inc     = pc_reg + 16'd1;
   assign imem_addr  = pc_reg;
   assign halted     = (state == S_HALTED);
   assign imem_rd_en = (state == S_RUN) && !branch_resolve && !data_hazard && !PC_hazard;

   // ret outranks call, call outranks a taken branch; not-taken resumes in line
   always_comb begin
      target = pc_reg;
      if (ret)
         target = ret_addr;
      else if (call)
         target = {pc_reg[15:12], call_target};
      else if (branch_taken)
         target = branch_target;
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc_reg;
      instr_nxt  = instruction;
      pc_out_nxt = PC_out;
      valid_nxt  = valid_out;
      upd_nxt    = 1'b0;
      stall_inc  = 1'b0;
      if (state != S_HALTED) begin
         if (branch_resolve) begin
            pc_nxt    = target;
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
            upd_nxt   = 1'b1;
            state_nxt = S_RUN;
         end else if (data_hazard) begin
            stall_inc = 1'b1;
         end else if (state == S_WAIT) begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
            stall_inc = 1'b1;
         end else if (PC_hazard) begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
            state_nxt = S_WAIT;
         end else begin
            instr_nxt  = imem_data;
            pc_out_nxt = pc_inc;
            valid_nxt  = 1'b1;
            if (imem_data[15:12] == HALT_OPC)
               state_nxt = S_HALTED;
            else
               pc_nxt = pc_inc;
         end
      end
      stall_nxt = (stall_inc && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RUN;
         pc_reg      <= 16'h0000;
         instruction <= NOP_INSTR;
         PC_out      <= 16'h0000;
         valid_out   <= 1'b0;
         PC_update   <= 1'b0;
         stall_cnt   <= 16'h0000;
      end else begin
         state       <= state_nxt;
         pc_reg      <= pc_nxt;
         instruction <= instr_nxt;
         PC_out      <= pc_out_nxt;
         valid_out   <= valid_nxt;
         PC_update   <= upd_nxt;
         stall_cnt   <= stall_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with a queue of expected IF/ID results
// filled as fetches are driven and drained after each fetching edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_hazard = 1'b0, PC_hazard = 1'b0;
   logic        branch_resolve = 1'b0, branch_taken = 1'b0, call = 1'b0, ret = 1'b0;
   logic [15:0] branch_target = '0, ret_addr = '0;
   logic [11:0] call_target = '0;
   logic [15:0] imem_data, imem_addr, instruction, PC_out, stall_cnt;
   logic        imem_rd_en, valid_out, PC_update, halted;

   logic        halt_en = 1'b0;
   logic [15:0] halt_addr = 16'h0020;

   int          tests = 0;
   int          fails = 0;
   logic [32:0] sb[$];
   logic [32:0] exp_e;

   fetch_unit dut (
      .clk(clk), .rst(rst), .data_hazard(data_hazard), .PC_hazard(PC_hazard),
      .branch_resolve(branch_resolve), .branch_taken(branch_taken),
      .branch_target(branch_target), .call(call), .call_target(call_target),
      .ret(ret), .ret_addr(ret_addr), .imem_data(imem_data), .imem_addr(imem_addr),
      .imem_rd_en(imem_rd_en), .instruction(instruction), .PC_out(PC_out),
      .valid_out(valid_out), .PC_update(PC_update), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (halt_en && a == halt_addr) return 16'hF000;
      if (a == 16'h0000) return 16'h1123;
      if (a == 16'h0001) return 16'h2456;
      return {4'h1, a[11:0]};
   endfunction

   assign imem_data = mem_word(imem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      data_hazard = 0; PC_hazard = 0; branch_resolve = 0; branch_taken = 0;
      call = 0; ret = 0;
   endtask

   task automatic push_fetch(input logic [15:0] a);
      sb.push_back({mem_word(a), a + 16'd1, 1'b1});
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs();
      tick(); tick();
      tests++; if ({instruction, PC_out, valid_out} !== {16'h0000, 16'h0000, 1'b0}) begin
         fails++; $display("FAIL reset_ifid got %h exp %h", {instruction, PC_out, valid_out}, 33'h0); end
      tests++; if ({PC_update, halted, stall_cnt, imem_addr} !== 34'h0) begin
         fails++; $display("FAIL reset_status got %h exp 0", {PC_update, halted, stall_cnt, imem_addr}); end
      rst = 0;
   endtask

   task automatic test_basic_fetch();
      tests++; if ({imem_addr, imem_rd_en} !== {16'h0000, 1'b1}) begin
         fails++; $display("FAIL first_fetch_addr got %h exp %h", {imem_addr, imem_rd_en}, {16'h0000, 1'b1}); end
      for (int i = 0; i < 2; i++) begin
         push_fetch(16'(i));
         tick();
         exp_e = sb.pop_front();
         tests++; if ({instruction, PC_out, valid_out} !== exp_e) begin
            fails++; $display("FAIL basic_fetch%0d got %h exp %h", i, {instruction, PC_out, valid_out}, exp_e); end
      end
   endtask

   task automatic test_data_hazard();
      for (int a = 2; a < 5; a++) begin
         push_fetch(16'(a)); tick();
         exp_e = sb.pop_front();
         tests++; if ({instruction, PC_out, valid_out} !== exp_e) begin
            fails++; $display("FAIL pre_hazard_fetch got %h exp %h", {instruction, PC_out, valid_out}, exp_e); end
      end
      data_hazard = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if ({instruction, PC_out, valid_out, imem_addr, imem_rd_en} !== {16'h1004, 16'h0005, 1'b1, 16'h0005, 1'b0}) begin
            fails++; $display("FAIL dh_freeze got %h exp %h", {instruction, PC_out, valid_out, imem_addr, imem_rd_en},
                              {16'h1004, 16'h0005, 1'b1, 16'h0005, 1'b0}); end
      end
      tests++; if (stall_cnt !== 16'd3) begin
         fails++; $display("FAIL dh_stall_cnt got %0d exp 3", stall_cnt); end
      data_hazard = 0;
      push_fetch(16'h0005); tick();
      exp_e = sb.pop_front();
      tests++; if ({instruction, PC_out, valid_out} !== exp_e) begin
         fails++; $display("FAIL dh_resume got %h exp %h", {instruction, PC_out, valid_out}, exp_e); end
   endtask

   task automatic test_pc_hazard();
      for (int a = 6; a < 8; a++) begin push_fetch(16'(a)); tick(); void'(sb.pop_front()); end
      tests++; if (imem_addr !== 16'h0008) begin
         fails++; $display("FAIL ph_start_addr got %h exp 0008", imem_addr); end
      PC_hazard = 1;
      tick();
      tests++; if ({instruction, valid_out, imem_addr, stall_cnt} !== {16'h0000, 1'b0, 16'h0008, 16'd3}) begin
         fails++; $display("FAIL ph_bubble got %h exp %h", {instruction, valid_out, imem_addr, stall_cnt}, {16'h0000, 1'b0, 16'h0008, 16'd3}); end
      tick(); tick();
      tests++; if ({instruction, valid_out, imem_addr, imem_rd_en, stall_cnt, PC_update} !== {16'h0000, 1'b0, 16'h0008, 1'b0, 16'd5, 1'b0}) begin
         fails++; $display("FAIL wait_state got %h exp %h", {instruction, valid_out, imem_addr, imem_rd_en, stall_cnt, PC_update},
                           {16'h0000, 1'b0, 16'h0008, 1'b0, 16'd5, 1'b0}); end
      branch_resolve = 1; branch_taken = 1; branch_target = 16'h0040;
      tick();
      tests++; if ({PC_update, valid_out, instruction, imem_addr, stall_cnt} !== {1'b1, 1'b0, 16'h0000, 16'h0040, 16'd5}) begin
         fails++; $display("FAIL resolve_taken got %h exp %h", {PC_update, valid_out, instruction, imem_addr, stall_cnt},
                           {1'b1, 1'b0, 16'h0000, 16'h0040, 16'd5}); end
      clear_inputs();
      push_fetch(16'h0040); tick();
      exp_e = sb.pop_front();
      tests++; if ({instruction, PC_out, valid_out, PC_update} !== {exp_e, 1'b0}) begin
         fails++; $display("FAIL target_fetch got %h exp %h", {instruction, PC_out, valid_out, PC_update}, {exp_e, 1'b0}); end
   endtask

   task automatic test_call_ret();
      branch_resolve = 1; branch_taken = 1; branch_target = 16'hA008;
      tick();
      branch_taken = 0; call = 1; call_target = 12'h123;
      tick();
      tests++; if (imem_addr !== 16'hA123) begin
         fails++; $display("FAIL call_target got %h exp a123", imem_addr); end
      ret = 1; ret_addr = 16'h0300;
      tick();
      tests++; if (imem_addr !== 16'h0300) begin
         fails++; $display("FAIL ret_priority got %h exp 0300", imem_addr); end
      call = 0; ret = 0;
      tick();
      tests++; if ({imem_addr, PC_update} !== {16'h0300, 1'b1}) begin
         fails++; $display("FAIL not_taken got %h exp %h", {imem_addr, PC_update}, {16'h0300, 1'b1}); end
      branch_taken = 1; branch_target = 16'h0010; data_hazard = 1;
      tick();
      tests++; if ({imem_addr, stall_cnt, PC_update} !== {16'h0010, 16'd5, 1'b1}) begin
         fails++; $display("FAIL resolve_over_dh got %h exp %h", {imem_addr, stall_cnt, PC_update}, {16'h0010, 16'd5, 1'b1}); end
      clear_inputs();
      push_fetch(16'h0010); tick();
      exp_e = sb.pop_front();
      tests++; if ({instruction, PC_out, valid_out} !== exp_e) begin
         fails++; $display("FAIL post_resolve_fetch got %h exp %h", {instruction, PC_out, valid_out}, exp_e); end
   endtask

   task automatic test_wrap();
      branch_resolve = 1; branch_taken = 1; branch_target = 16'hFFFF;
      tick(); clear_inputs();
      push_fetch(16'hFFFF); tick();
      exp_e = sb.pop_front();
      tests++; if ({instruction, PC_out, valid_out, imem_addr} !== {exp_e, 16'h0000}) begin
         fails++; $display("FAIL pc_wrap got %h exp %h", {instruction, PC_out, valid_out, imem_addr}, {exp_e, 16'h0000}); end
   endtask

   task automatic test_halt();
      halt_en = 1;
      branch_resolve = 1; branch_taken = 1; branch_target = halt_addr;
      tick(); clear_inputs();
      push_fetch(halt_addr); tick();
      exp_e = sb.pop_front();
      tests++; if ({instruction, PC_out, valid_out, halted, imem_addr, imem_rd_en} !== {exp_e, 1'b1, halt_addr, 1'b0}) begin
         fails++; $display("FAIL halt_fetch got %h exp %h", {instruction, PC_out, valid_out, halted, imem_addr, imem_rd_en},
                           {exp_e, 1'b1, halt_addr, 1'b0}); end
      branch_resolve = 1; branch_taken = 1; branch_target = 16'h0040; data_hazard = 1;
      tick(); tick();
      tests++; if ({instruction, PC_out, valid_out, halted, imem_addr, stall_cnt, PC_update} !==
                   {16'hF000, 16'h0021, 1'b1, 1'b1, halt_addr, 16'd5, 1'b0}) begin
         fails++; $display("FAIL halt_hold got %h exp %h", {instruction, PC_out, valid_out, halted, imem_addr, stall_cnt, PC_update},
                           {16'hF000, 16'h0021, 1'b1, 1'b1, halt_addr, 16'd5, 1'b0}); end
      clear_inputs(); rst = 1;
      tick(); rst = 0;
      tests++; if ({halted, imem_addr, instruction, valid_out, stall_cnt} !== 50'h0) begin
         fails++; $display("FAIL halt_reset got %h exp 0", {halted, imem_addr, instruction, valid_out, stall_cnt}); end
      halt_en = 0;
   endtask

   task automatic test_stall_saturate();
      data_hazard = 1;
      repeat (65535) tick();
      tests++; if (stall_cnt !== 16'hFFFF) begin
         fails++; $display("FAIL stall_reach_max got %h exp ffff", stall_cnt); end
      tick(); tick();
      tests++; if (stall_cnt !== 16'hFFFF) begin
         fails++; $display("FAIL stall_saturate got %h exp ffff", stall_cnt); end
      rst = 1; tick(); rst = 0; clear_inputs();
      tests++; if (stall_cnt !== 16'h0000) begin
         fails++; $display("FAIL stall_reset got %h exp 0000", stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_data_hazard();
      test_pc_hazard();
      test_call_ret();
      test_wrap();
      test_halt();
      test_stall_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NOP_INSTR, 16'h0000, instruction word injected as a pipeline bubble.
REQ-002 Parameter HALT_OPC, 4'hF, opcode (instr[15:12]) that halts fetch.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 data_hazard  in  1  ID data hazard; freeze PC and the IF/ID outputs.
REQ-006 PC_hazard  in  1  control instruction in ID; stop fetching until resolved.
REQ-007 branch_resolve  in  1  one-cycle pulse: pending control instruction resolved.
REQ-008 branch_taken  in  1  with branch_resolve: conditional branch taken.
REQ-009 branch_target  in  16  branch destination PC.
REQ-010 call  in  1  with branch_resolve: resolved instruction is a call.
REQ-011 call_target  in  12  call target field; destination = {PC_reg[15:12], call_target}.
REQ-012 ret  in  1  with branch_resolve: resolved instruction is a return.
REQ-013 ret_addr  in  16  return destination PC.
REQ-014 imem_data  in  16  instruction memory read data, combinational from imem_addr.
REQ-015 imem_addr  out  16  instruction memory address, equal to PC_reg.
REQ-016 imem_rd_en  out  1  high only in RUN with no hazard and no resolve.
REQ-017 instruction  out  16  registered IF/ID instruction.
REQ-018 PC_out  out  16  registered PC_reg+1 of the fetched instruction.
REQ-019 valid_out  out  1  registered; instruction holds a real fetched word.
REQ-020 PC_update  out  1  registered one-cycle pulse: PC reloaded after resolve; releases ID.
REQ-021 halted  out  1  high in HALTED.
REQ-022 stall_cnt  out  16  saturating count of cycles spent in WAIT or with data_hazard high.

Function
REQ-023 States: RUN, WAIT, HALTED; state is internal, exposed only via halted.
REQ-024 Priority per cycle: rst > branch_resolve > data_hazard > PC_hazard > normal fetch.
REQ-025 RUN, normal fetch: instruction<=imem_data, PC_out<=PC_reg+1, valid_out<=1, PC_reg<=PC_reg+1.
REQ-026 PC arithmetic is 16-bit modulo: PC_reg 16'hFFFF increments to 16'h0000, PC_out likewise.
REQ-027 data_hazard (no resolve): PC_reg, instruction, PC_out, valid_out hold; state unchanged; stall_cnt increments.
REQ-028 PC_hazard in RUN (no data_hazard, no resolve): instruction<=NOP_INSTR, valid_out<=0, PC_reg holds, go WAIT.
REQ-029 WAIT: PC_reg holds, instruction=NOP_INSTR, valid_out=0, stall_cnt increments each cycle.
REQ-030 branch_resolve (RUN or WAIT): PC_reg<=target, instruction<=NOP_INSTR, valid_out<=0, PC_update<=1, state<=RUN.
REQ-031 Target select: ret -> ret_addr; else call -> {PC_reg[15:12], call_target}; else branch_taken -> branch_target; else PC_reg (not taken, fetch resumes in line).
REQ-032 PC_update is 0 on every cycle other than the one following branch_resolve.
REQ-033 Fetched word with imem_data[15:12]==HALT_OPC: latched as a normal fetch (valid_out=1), PC_reg holds, go HALTED.
REQ-034 HALTED: all outputs hold; imem_rd_en=0; branch_resolve, hazards ignored; exit only via rst.
REQ-035 stall_cnt saturates at 16'hFFFF; never wraps.
REQ-036 branch_resolve concurrent with data_hazard: resolve wins; hazard cycle not counted.

Reset
REQ-037 rst (any state, mid-stall or mid-WAIT): PC_reg=16'h0000, state=RUN.
REQ-038 rst outputs next cycle: instruction=NOP_INSTR, PC_out=16'h0000, valid_out=0, PC_update=0, halted=0, stall_cnt=0.
REQ-039 First fetch from address 16'h0000 on the first cycle with rst low.

Verification
REQ-040 Reset then imem returns 16'h1123,16'h2456 -> instruction 16'h1123/PC_out 1, then 16'h2456/PC_out 2, valid_out=1.
REQ-041 data_hazard high 3 cycles at PC 5 -> outputs frozen, imem_addr stays 5, stall_cnt=3, fetch resumes at 5.
REQ-042 PC_hazard at PC 8, WAIT 2 cycles, resolve taken target 16'h0040 -> NOP bubbles, PC_update pulse, next fetch 16'h0040.
REQ-043 Resolve with call=1, call_target 12'h123, PC_reg 16'hA008 -> next fetch 16'hA123; ret=1 with call=1 -> ret_addr wins.
REQ-044 PC_reg 16'hFFFF normal fetch -> PC_out 16'h0000, next imem_addr 16'h0000.
REQ-045 Fetch 16'hF000 -> latched valid, halted=1, resolve ignored; rst -> PC 0, halted=0.
